// File: rtl/sync_fifo_2p.sv
// Single-clock FIFO over an inferred simple dual-port RAM with registered read data,
// fill-level reporting, threshold flags and sticky overflow/underflow errors.
module sync_fifo_2p #(
    parameter int unsigned LOG2N      = 6,
    parameter int unsigned N          = 1 << LOG2N,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned AFULL_TH   = N - 4,
    parameter int unsigned AEMPTY_TH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclr,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  wrreq,
    input  logic                  rdreq,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  q_valid,
    output logic [LOG2N:0]        usedw,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned PW = LOG2N;
    localparam int unsigned CW = LOG2N + 1;
    localparam logic AFULL_RST = (AFULL_TH == 0);

    logic [DATA_WIDTH-1:0] mem [N];

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  q_valid_q, q_valid_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  afull_q, afull_d;
    logic                  aempty_q, aempty_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  wr_ok;
    logic                  rd_ok;

    // Acceptance uses the registered full/empty only; there is no write-to-read bypass.
    always_comb begin
        wr_ok     = wrreq & ~full_q;
        rd_ok     = rdreq & ~empty_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;
        q_valid_d = 1'b0;
        ovf_d     = ovf_q;
        unf_d     = unf_q;

        if (sclr) begin
            wr_ok     = 1'b0;
            rd_ok     = 1'b0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            rd_data_d = '0;
            ovf_d     = 1'b0;
            unf_d     = 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (rd_ok) begin
                rd_ptr_d  = rd_ptr_q + PW'(1);
                rd_data_d = mem[rd_ptr_q];
                q_valid_d = 1'b1;
            end
            if (wr_ok && !rd_ok) begin
                count_d = count_q + CW'(1);
            end else if (rd_ok && !wr_ok) begin
                count_d = count_q - CW'(1);
            end
            if (wrreq && full_q) begin
                ovf_d = 1'b1;
            end
            if (rdreq && empty_q) begin
                unf_d = 1'b1;
            end
        end

        // Flags follow the next-state count so they always agree with usedw.
        full_d   = (count_d == CW'(N));
        empty_d  = (count_d == CW'(0));
        afull_d  = (count_d >= CW'(AFULL_TH));
        aempty_d = (count_d <= CW'(AEMPTY_TH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
            q_valid_q <= 1'b0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            afull_q   <= AFULL_RST;
            aempty_q  <= 1'b1;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
            q_valid_q <= q_valid_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            afull_q   <= afull_d;
            aempty_q  <= aempty_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    // RAM array has no reset so it maps onto block memory.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= data;
        end
    end

    assign q            = rd_data_q;
    assign q_valid      = q_valid_q;
    assign usedw        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: doc/sync_fifo_2p.md
# sync_fifo_2p

Single-clock FIFO built on an inferred simple dual-port RAM. It generalises the team's dual-port RAM primitive with parametrised width and depth, internal pointer management, fill-level reporting, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It sits between NPU datapath stages that share one clock, for example DMA burst buffering and instruction queues, wherever a dual-clock structure is unnecessary.

## Interface
- LOG2N, 6, log2 of FIFO depth; legal range 2..16
- N, 1<<LOG2N, FIFO depth in words; not to be overridden independently
- DATA_WIDTH, 32, word width in bits
- AFULL_TH, N-4, almost_full asserts when usedw >= AFULL_TH
- AEMPTY_TH, 4, almost_empty asserts when usedw <= AEMPTY_TH

Ports:
- clk  in  1  single clock; all logic is on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- sclr  in  1  synchronous clear; has priority over wrreq and rdreq
- data  in  DATA_WIDTH  write data
- wrreq  in  1  write request
- rdreq  in  1  read request
- q  out  DATA_WIDTH  registered read data
- q_valid  out  1  high for one cycle when q carries a newly read word
- usedw  out  LOG2N+1  stored word count, 0..N
- full / empty  out  1  usedw==N / usedw==0
- almost_full / almost_empty  out  1  threshold flags, registered
- overflow / underflow  out  1  sticky error flags

## Operation
- Storage: array of N words of DATA_WIDTH. Write pointer and read pointer are each LOG2N bits and wrap modulo N. The count register is LOG2N+1 bits.
- Write accept: wr_ok = wrreq & ~full. On wr_ok, mem[wr_ptr] <= data and wr_ptr increments.
- Read accept: rd_ok = rdreq & ~empty. On rd_ok, q <= mem[rd_ptr], rd_ptr increments, and q_valid is 1 in the next cycle.
- full and empty are evaluated on the registered state at the start of the cycle. No bypass exists:
  - Full with wrreq & rdreq: the read is accepted, the write is rejected, and overflow is set.
  - Empty with wrreq & rdreq: the write is accepted, the read is rejected, and underflow is set.
- Count update:
  - +1 on wr_ok only.
  - −1 on rd_ok only.
  - Unchanged when both or neither are accepted.
- Rejected write (wrreq & full): memory and pointers are unchanged; overflow <= 1.
- Rejected read (rdreq & empty): q holds, q_valid is 0; underflow <= 1.
- overflow and underflow stay set until rst_n or sclr.
- q holds its last value when no read is accepted.
- Flags full, empty, almost_full, almost_empty and usedw are registered. They are derived from the next-state count, so they are consistent with usedw in the same cycle.
- sclr: pointers, count, q, q_valid and both sticky flags go to 0, and the flags go to their reset values. RAM contents are not cleared. Any wrreq or rdreq in the same cycle is ignored.
- Asynchronous reset (rst_n low) has the same effect as sclr, and may arrive mid-operation. Words in flight are discarded. After rst_n deasserts, the first edge may accept a write.

## Timing
- Reset values:
  - q=0, q_valid=0, usedw=0
  - full=0, empty=1
  - almost_full = (AFULL_TH==0), which is 0 for the defaults
  - almost_empty=1, overflow=0, underflow=0
- Write-to-read: a word written at edge t makes empty low after t. An rdreq in cycle t+1 is accepted at edge t+1, and q/q_valid are visible after t+1.
- Read latency: 1 clock from rdreq sampled to q valid. Sustained throughput is 1 read and 1 write per clock.
- A read accepted at full frees a slot that can be written in the following cycle.

## Test plan
- Reset: assert rst_n=0 mid-stream with usedw=5 -> all outputs at reset values asynchronously; after release, a write of 0xA5 followed by a read returns q=0xA5 with q_valid one cycle later.
- Fill: N=64, write 0..63 with no reads -> usedw=64 and full=1 after the 64th edge; almost_full first asserts when usedw=60; a 65th write sets overflow=1 and usedw stays 64.
- Drain: from full, hold rdreq for 66 cycles -> q = 0..63 in order, each with q_valid; empty=1 after the 64th read; almost_empty first asserts when usedw=4; the extra reads set underflow=1 and q holds 63.
- Simultaneous access: at usedw=10, wrreq&rdreq for 20 cycles -> usedw stays 10 and data stays in order. At empty, both asserted -> usedw=1 and underflow=1. At full, both asserted -> usedw=63 and overflow=1.
- Wrap-around: stream 200 incrementing words with random wrreq/rdreq densities of 30–90% -> output matches the scoreboard and usedw always equals writes accepted minus reads accepted.
- sclr: at usedw=37, assert sclr together with wrreq and rdreq -> usedw=0, empty=1 and sticky flags cleared next cycle; no write or read is accepted; the next write then read returns the new data.
